id_ex_pipe_reg: RTL and testbench

- Parametrised ID->EX pipeline register for the ARM core, replacing the fixed, always-load stage register.
- Adds a valid/ready handshake with a 2-entry skid buffer, so the stage sustains full throughput under back-pressure.
- Adds a working flush (branch taken) and bubble injection (hazard unit) that drop instructions cleanly.
- Payload is a generic DATA_W vector; the shared package provides the control/operand struct packed into it.

---
 rtl/arm_pipe_pkg.sv | 45 ++++
 rtl/sat_counter.sv | 31 +++
 rtl/id_ex_pipe_reg.sv | 123 ++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared ID->EX types for the ARM core pipeline.
// The payload struct is packed into the generic DATA_W vector carried by
// id_ex_pipe_reg; ID_EX_W is the width a core-level instance should use.
package arm_pipe_pkg;

  // ALU command issued by the decoder to the EX stage
  typedef enum logic [3:0] {
    EXE_NOP = 4'd0,
    EXE_MOV = 4'd1,
    EXE_ADD = 4'd2,
    EXE_ADC = 4'd3,
    EXE_SUB = 4'd4,
    EXE_SBC = 4'd5,
    EXE_AND = 4'd6,
    EXE_ORR = 4'd7,
    EXE_EOR = 4'd8,
    EXE_MVN = 4'd9
  } exe_cmd_t;

  // Control bits produced by ID for use in EX/MEM/WB
  typedef struct packed {
    logic     wb_en;
    logic     mem_r_en;
    logic     mem_w_en;
    logic     b;
    logic     s;
    exe_cmd_t exe_cmd;
    logic     imm;
  } id_ex_ctrl_t;

  // Everything that crosses the ID->EX boundary
  typedef struct packed {
    id_ex_ctrl_t ctrl;
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;
    logic [3:0]  sr;
  } id_ex_payload_t;

  localparam int ID_EX_W = $bits(id_ex_payload_t);

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: adds i_inc whenever i_en is high and sticks at
// all-ones instead of wrapping. Used by the optional ID->EX perf counters.
module sat_counter #(
  parameter int W     = 32,
  parameter int INC_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [INC_W-1:0] i_inc,
  output logic [W-1:0]     o_cnt
);

  logic [W-1:0] r_cnt;
  logic [W:0]   w_sum;

  // One extra bit catches the carry that signals saturation
  assign w_sum = {1'b0, r_cnt} + {{(W+1-INC_W){1'b0}}, i_inc};

  // Count register, clamped at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with a valid/ready handshake and a 2-entry skid
// buffer (main + skid), plus flush and hazard bubble injection.
//
// Handshake: a beat moves on an interface in a cycle where valid and ready
// are both high at the rising edge; valid never depends on ready. in_ready
// is the inverted skid-valid flop, so it has no combinational path from
// out_ready. bubble and flush veto acceptance even when in_ready is high.
//
// Optional: define ID_EX_PERF_EN to add stall_cnt / flush_cnt outputs.
module id_ex_pipe_reg
  import arm_pipe_pkg::*;
#(
  parameter int                DATA_W      = 128,
  parameter logic [DATA_W-1:0] RST_PAYLOAD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              bubble,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
`ifdef ID_EX_PERF_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt,
`endif
  output logic [1:0]        occupancy
);

  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic [1:0]        r_occ;

  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_main_valid_n;
  logic [DATA_W-1:0] w_main_data_n;
  logic              w_skid_valid_n;
  logic [DATA_W-1:0] w_skid_data_n;
  logic [1:0]        w_occ_n;

  assign w_in_fire  = in_valid & ~r_skid_valid & ~bubble & ~flush;
  assign w_out_fire = r_main_valid & out_ready;

  // Next-state: flush clears everything; otherwise refill main from skid
  // first (keeps order), then from the input, or park the input in skid.
  always_comb begin
    w_main_valid_n = r_main_valid;
    w_main_data_n  = r_main_data;
    w_skid_valid_n = r_skid_valid;
    w_skid_data_n  = r_skid_data;
    if (flush) begin
      w_main_valid_n = 1'b0;
      w_main_data_n  = RST_PAYLOAD;
      w_skid_valid_n = 1'b0;
      w_skid_data_n  = RST_PAYLOAD;
    end else if (!r_main_valid || w_out_fire) begin
      if (r_skid_valid) begin
        w_main_valid_n = 1'b1;
        w_main_data_n  = r_skid_data;
        w_skid_valid_n = 1'b0;
      end else if (w_in_fire) begin
        w_main_valid_n = 1'b1;
        w_main_data_n  = in_data;
      end else begin
        w_main_valid_n = 1'b0;
      end
    end else if (w_in_fire) begin
      w_skid_valid_n = 1'b1;
      w_skid_data_n  = in_data;
    end
    w_occ_n = {1'b0, w_main_valid_n} + {1'b0, w_skid_valid_n};
  end

  // Storage and registered occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_main_data  <= RST_PAYLOAD;
      r_skid_valid <= 1'b0;
      r_skid_data  <= RST_PAYLOAD;
      r_occ        <= 2'd0;
    end else begin
      r_main_valid <= w_main_valid_n;
      r_main_data  <= w_main_data_n;
      r_skid_valid <= w_skid_valid_n;
      r_skid_data  <= w_skid_data_n;
      r_occ        <= w_occ_n;
    end
  end

  assign in_ready  = ~r_skid_valid;
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;
  assign occupancy = r_occ;

`ifdef ID_EX_PERF_EN
  logic w_stall;
  assign w_stall = r_main_valid & ~out_ready;

  sat_counter #(.W(32), .INC_W(1)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_stall),
    .i_inc (1'b1),
    .o_cnt (stall_cnt)
  );

  sat_counter #(.W(32), .INC_W(2)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_en  (flush),
    .i_inc (r_occ),
    .o_cnt (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: an ordered-queue model of the stage (up to two
// entries, flush empties it) checked every cycle, plus directed scenarios
// with literal expected values.
module tb_id_ex_pipe_reg;

  localparam int W = 128;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         bubble;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;
`ifdef ID_EX_PERF_EN
  logic [31:0]  stall_cnt;
  logic [31:0]  flush_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.DATA_W(W), .RST_PAYLOAD('0)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bubble    (bubble),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef ID_EX_PERF_EN
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
`endif
    .occupancy (occupancy)
  );

  // ---------------- scoreboard ----------------
  int           checks   = 0;
  int           failures = 0;
  bit           chk_en   = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] fired_q[$];
  int           m_stall;
  int           m_flush;
  bit           m_rdy;
  bit           m_ofire;
  bit           m_ifire;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the stage is an ordered queue of at most two entries.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_stall = 0;
      m_flush = 0;
    end else begin
      m_rdy   = exp_q.size() < 2;
      m_ofire = (exp_q.size() > 0) && out_ready;
      m_ifire = in_valid && m_rdy && !bubble && !flush;
      if (exp_q.size() > 0 && !out_ready) m_stall++;
      if (flush) begin
        m_flush += exp_q.size();
        exp_q.delete();
      end else begin
        if (m_ofire) void'(exp_q.pop_front());
        if (m_ifire) exp_q.push_back(in_data);
      end
    end
  end

  // Record what EX actually consumed
  always @(posedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready) fired_q.push_back(out_data);
  end

  // Per-cycle compare against the model, away from the clock edge
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("occupancy", W'(occupancy), W'(exp_q.size()));
      chk("out_valid", W'(out_valid), W'(exp_q.size() > 0));
      chk("in_ready", W'(in_ready), W'(exp_q.size() < 2));
      if (exp_q.size() > 0) chk("out_data", out_data, exp_q[0]);
`ifdef ID_EX_PERF_EN
      chk("stall_cnt", W'(stall_cnt), W'(m_stall));
      chk("flush_cnt", W'(flush_cnt), W'(m_flush));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy,
                       input logic bub, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    bubble    = bub;
    flush     = fl;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_c;
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc();
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_occ", W'(occupancy), W'(0));
    chk("rst_out_data", out_data, W'(0));
    rst = 1'b0;
    chk_en = 1'b1;
    cyc();

    // Streaming 1,2,3 with EX always ready
    drive(1'b1, W'(1), 1'b1, 1'b0, 1'b0);
    cyc();
    chk("stream_d1", out_data, W'(1));
    chk("stream_occ1", W'(occupancy), W'(1));
    in_data = W'(2);
    cyc();
    chk("stream_d2", out_data, W'(2));
    in_data = W'(3);
    cyc();
    chk("stream_d3", out_data, W'(3));
    chk("stream_occ3", W'(occupancy), W'(1));
    in_valid = 1'b0;
    cyc();
    chk("stream_drain", W'(out_valid), W'(0));

    // Back-pressure fills the skid entry
    drive(1'b1, W'('hA), 1'b0, 1'b0, 1'b0);
    cyc();
    in_data = W'('hB);
    cyc();
    chk("skid_occ2", W'(occupancy), W'(2));
    chk("skid_in_ready0", W'(in_ready), W'(0));
    chk("skid_hold_a", out_data, W'('hA));
    in_valid = 1'b0;
    cyc();
    chk("skid_hold_a2", out_data, W'('hA));
    out_ready = 1'b1;
    cyc();
    chk("skid_out_b", out_data, W'('hB));
    chk("skid_in_ready1", W'(in_ready), W'(1));
    chk("skid_occ1", W'(occupancy), W'(1));
    cyc();
    chk("skid_empty", W'(occupancy), W'(0));

    // Bubble: two NOP cycles, input taken once bubble drops
    drive(1'b1, W'(5), 1'b1, 1'b0, 1'b0);
    cyc();
    chk("bub_pre_d", out_data, W'(5));
    bubble  = 1'b1;
    in_data = W'(6);
    cyc();
    chk("bub_nop1", W'(out_valid), W'(0));
    cyc();
    chk("bub_nop2", W'(out_valid), W'(0));
    bubble = 1'b0;
    cyc();
    chk("bub_accept", out_data, W'(6));
    chk("bub_valid", W'(out_valid), W'(1));
    in_valid = 1'b0;
    cyc();

    // Flush at occupancy 2 with an input offered
    drive(1'b1, W'('h11), 1'b0, 1'b0, 1'b0);
    cyc();
    in_data = W'('h12);
    cyc();
    chk("fl_occ2", W'(occupancy), W'(2));
    drive(1'b1, W'('hC), 1'b0, 1'b1, 1'b1);
    cyc();
    chk("fl_valid", W'(out_valid), W'(0));
    chk("fl_occ", W'(occupancy), W'(0));
    chk("fl_in_ready", W'(in_ready), W'(1));
    chk("fl_data", out_data, W'(0));
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc();
    chk("fl_stays_empty", W'(out_valid), W'(0));

    // Asynchronous reset mid-stream at occupancy 2
    drive(1'b1, W'('h21), 1'b0, 1'b0, 1'b0);
    cyc();
    in_data = W'('h22);
    cyc();
    chk("ar_occ2", W'(occupancy), W'(2));
    #2;
    rst = 1'b1;
    #1;
    chk("ar_out_valid", W'(out_valid), W'(0));
    chk("ar_in_ready", W'(in_ready), W'(1));
    chk("ar_occ", W'(occupancy), W'(0));
    chk("ar_data", out_data, W'(0));
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc();
    rst = 1'b0;
    cyc();

`ifdef ID_EX_PERF_EN
    // Five stalled edges, then flush at occupancy 2 while EX consumes
    drive(1'b1, W'('h31), 1'b0, 1'b0, 1'b0);
    cyc();
    in_data = W'('h32);
    cyc();
    in_valid = 1'b0;
    repeat (4) cyc();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    cyc();
    chk("perf_stall", W'(stall_cnt), W'(5));
    chk("perf_flush", W'(flush_cnt), W'(2));
    flush = 1'b0;
    cyc();
`endif

    // Mixed traffic checked by the model every cycle
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom_range(1, 1000)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 15) == 0));
      cyc();
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc();

    n_c = 0;
    foreach (fired_q[k]) if (fired_q[k] == W'('hC)) n_c++;
    chk("fl_c_never_out", W'(n_c), W'(0));

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
